// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg
// Definitions shared by the write-back stage and the load aligner:
//   - LOAD_OP_W and the one-hot bit positions of the load_op vector
//     (LOP_LDB .. LOP_STW)
//   - REG_ADDR_W, the GPR address width
//   - RESET_PC_DEFAULT, the reset value of the trace PC register
//   - sign/zero-extension helpers for sub-word loads
package wb_stage_pkg;

  localparam int LOAD_OP_W  = 8;
  localparam int REG_ADDR_W = 5;

  localparam int LOP_LDB  = 0;
  localparam int LOP_LDH  = 1;
  localparam int LOP_LDW  = 2;
  localparam int LOP_LDBU = 3;
  localparam int LOP_LDHU = 4;
  localparam int LOP_STB  = 5;
  localparam int LOP_STH  = 6;
  localparam int LOP_STW  = 7;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  typedef logic [LOAD_OP_W-1:0]  load_op_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

  function automatic logic [31:0] zext8(input logic [7:0] b);
    return {24'h0, b};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] h);
    return {16'h0, h};
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align
// Purely combinational load-data aligner. Picks the addressed byte or
// halfword out of a 32-bit memory word and extends it to 32 bits
// according to the one-hot load opcode.
// Ports:
//   rdata    in  [31:0]  raw word returned by memory
//   addr     in  [1:0]   low address bits of the access
//   load_op  in  [7:0]   one-hot load/store opcode (see wb_stage_pkg)
//   value    out [31:0]  aligned, extended load value
module load_align
  import wb_stage_pkg::*;
(
  input  logic [31:0]          rdata,
  input  logic [1:0]           addr,
  input  logic [LOAD_OP_W-1:0] load_op,
  output logic [31:0]          value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  // Halfword accesses ignore addr[0]; a misaligned halfword is simply
  // truncated to its containing aligned halfword.
  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

  // Each candidate is masked by its own opcode bit and the results are
  // ORed, so an all-zero opcode yields 0 and a multi-hot opcode yields
  // a well-defined (if meaningless) value instead of a priority chain.
  assign value = ({32{load_op[LOP_LDB]}}  & sext8(byte_sel))
               | ({32{load_op[LOP_LDH]}}  & sext16(half_sel))
               | ({32{load_op[LOP_LDW]}}  & rdata)
               | ({32{load_op[LOP_LDBU]}} & zext8(byte_sel))
               | ({32{load_op[LOP_LDHU]}} & zext16(half_sel));

  // Store opcodes travel on the same bus but never produce a load value.
  logic unused_store_ops;
  assign unused_store_ops = |load_op[LOP_STW:LOP_STB];

endmodule

// File: rtl/wb_stage.sv
// wb_stage
// Write-back stage of the in-order LA32R pipeline. Takes the registered
// memory-stage outputs plus the data SRAM read data (which arrives only
// in the first cycle an instruction is presented), keeps that data in a
// hold buffer across stalls, aligns loads, commits register writes,
// drives the decode bypass and counts retired instructions.
// Optional build macro: WB_TRACE_EN adds the debug_wb_* trace ports.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   handshake with the memory stage
//   commit_ready          downstream permission to commit
//   pc, alu_result        instruction PC, ALU result / load address
//   load_op, res_from_mem one-hot load/store op, result-is-load flag
//   gr_we, dest           GPR write enable and destination
//   data_sram_rdata       SRAM read data
//   rf_we/rf_waddr/rf_wdata   register-file write port
//   fwd_valid/fwd_dest/fwd_data  bypass to decode
//   retire_cnt            committed instruction count
//   debug_wb_*            (WB_TRACE_EN only) commit trace
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  commit_ready,
  input  logic [31:0]           pc,
  input  logic [31:0]           alu_result,
  input  logic [LOAD_OP_W-1:0]  load_op,
  input  logic                  res_from_mem,
  input  logic                  gr_we,
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic [31:0]           data_sram_rdata,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [31:0]           rf_wdata,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_dest,
  output logic [31:0]           fwd_data,
  output logic [CNT_W-1:0]      retire_cnt
`ifdef WB_TRACE_EN
  ,
  output logic [31:0]           debug_wb_pc,
  output logic [3:0]            debug_wb_rf_we,
  output logic [REG_ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [31:0]           debug_wb_rf_wdata
`endif
);

  logic        commit;
  logic        accept_q;
  logic        fresh;
  logic [31:0] rdata_hold;
  logic [31:0] rdata_eff;
  logic [31:0] load_value;
  logic [31:0] wdata;
  logic [31:0] pc_q;

  assign in_ready = ~rst & (~in_valid | commit_ready);

  // Gated by reset so that nothing retires or writes the register file
  // in a cycle where reset is asserted.
  assign commit = in_valid & commit_ready & ~rst;

  // accept_q remembers whether we were ready last cycle, i.e. whether the
  // instruction now presented has just arrived and its SRAM data is live.
  always_ff @(posedge clk) begin
    if (rst) accept_q <= 1'b0;
    else     accept_q <= in_ready;
  end

  assign fresh = in_valid & accept_q;

  // The SRAM only drives the load word for one cycle; capture it then so
  // a stall of any length still commits the original data.
  always_ff @(posedge clk) begin
    if (rst)        rdata_hold <= 32'h0;
    else if (fresh) rdata_hold <= data_sram_rdata;
  end

  assign rdata_eff = accept_q ? data_sram_rdata : rdata_hold;

  load_align u_load_align (
    .rdata   (rdata_eff),
    .addr    (alu_result[1:0]),
    .load_op (load_op),
    .value   (load_value)
  );

  assign wdata = res_from_mem ? load_value : alu_result;

  // Writes to r0 are deliberately not filtered here; the register file
  // discards them itself.
  assign rf_we    = commit & gr_we;
  assign rf_waddr = dest;
  assign rf_wdata = wdata;

  // The bypass is live for the whole time the instruction sits here,
  // stalled or not, so decode never has to wait for the commit.
  assign fwd_valid = in_valid & gr_we & (dest != '0);
  assign fwd_dest  = dest;
  assign fwd_data  = wdata;

  always_ff @(posedge clk) begin
    if (rst)         retire_cnt <= '0;
    else if (commit) retire_cnt <= retire_cnt + CNT_W'(1);
  end

  // PC of the last retired instruction, kept for trace/debug probing.
  always_ff @(posedge clk) begin
    if (rst)         pc_q <= RESET_PC;
    else if (commit) pc_q <= pc;
  end

  logic unused_pc_q;
  assign unused_pc_q = ^pc_q;

`ifdef WB_TRACE_EN
  assign debug_wb_pc       = {32{commit}} & pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = {REG_ADDR_W{commit}} & dest;
  assign debug_wb_rf_wdata = {32{commit}} & wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage
// Scoreboard bench for wb_stage: the stimulus side pushes the expected
// commit for every instruction it issues, and an independent monitor on
// the falling clock edge checks the bypass during stalls and pops the
// expectation when the instruction commits.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        commit_ready;
  logic [31:0] pc;
  logic [31:0] alu_result;
  logic [7:0]  load_op;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] data_sram_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic [31:0] retire_cnt;

  wb_stage dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .commit_ready    (commit_ready),
    .pc              (pc),
    .alu_result      (alu_result),
    .load_op         (load_op),
    .res_from_mem    (res_from_mem),
    .gr_we           (gr_we),
    .dest            (dest),
    .data_sram_rdata (data_sram_rdata),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .fwd_valid       (fwd_valid),
    .fwd_dest        (fwd_dest),
    .fwd_data        (fwd_data),
    .retire_cnt      (retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        fwd_v;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned exp_retire = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: architectural meaning of each load opcode, using shifts
  // and integer arithmetic on the memory word.
  function automatic logic [31:0] ref_wdata(input logic [7:0] op,
                                            input logic [31:0] alu,
                                            input logic [31:0] word,
                                            input logic from_mem);
    int unsigned a;
    int unsigned b;
    int unsigned h;
    logic [31:0] acc;
    if (!from_mem) return alu;
    a   = alu % 4;
    b   = (word >> (8 * a)) % 256;
    h   = (word >> (16 * (a / 2))) % 65536;
    acc = 32'h0;
    if (op[0]) acc |= (b >= 128)   ? b + 32'hFFFF_FF00 : b;
    if (op[1]) acc |= (h >= 32768) ? h + 32'hFFFF_0000 : h;
    if (op[2]) acc |= word;
    if (op[3]) acc |= b;
    if (op[4]) acc |= h;
    return acc;
  endfunction

  // Issue one instruction: present it with its SRAM word in the first
  // cycle, keep it stalled for 'stall' cycles with junk on the SRAM bus,
  // then let it commit.
  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] alu,
                               input logic [31:0] word, input logic [31:0] junk,
                               input logic we, input logic [4:0] d,
                               input logic from_mem, input int stall);
    exp_t e;
    e.we    = we;
    e.waddr = d;
    e.wdata = ref_wdata(op, alu, word, from_mem);
    e.fwd_v = we && (d != 5'd0);
    exp_q.push_back(e);
    in_valid        = 1'b1;
    pc              = $urandom;
    load_op         = op;
    alu_result      = alu;
    gr_we           = we;
    dest            = d;
    res_from_mem    = from_mem;
    data_sram_rdata = word;
    commit_ready    = (stall == 0);
    for (int i = 1; i <= stall; i++) begin
      @(posedge clk); #1;
      data_sram_rdata = junk ^ i;
      commit_ready    = (i == stall);
    end
    @(posedge clk); #1;
    in_valid     = 1'b0;
    commit_ready = 1'b1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: checks every cycle an instruction is presented; pops the
  // expectation when it commits.
  always @(negedge clk) begin
    if (!rst && in_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("[TB] FAIL scoreboard_underflow: got valid with empty queue at %0t", $time);
      end else begin
        checkOutput("in_ready",  32'(in_ready),  32'(commit_ready));
        checkOutput("fwd_valid", 32'(fwd_valid), 32'(exp_q[0].fwd_v));
        checkOutput("fwd_dest",  32'(fwd_dest),  32'(exp_q[0].waddr));
        checkOutput("fwd_data",  fwd_data,       exp_q[0].wdata);
        if (commit_ready) begin
          checkOutput("rf_we",      32'(rf_we),    32'(exp_q[0].we));
          checkOutput("rf_waddr",   32'(rf_waddr), 32'(exp_q[0].waddr));
          checkOutput("rf_wdata",   rf_wdata,      exp_q[0].wdata);
          checkOutput("retire_cnt", retire_cnt,    exp_retire);
          exp_retire++;
          void'(exp_q.pop_front());
        end else begin
          checkOutput("rf_we_stall", 32'(rf_we), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] op;
    int         r;
    rst             = 1'b1;
    in_valid        = 1'b0;
    commit_ready    = 1'b1;
    pc              = 32'h0;
    alu_result      = 32'h0;
    load_op         = 8'h0;
    res_from_mem    = 1'b0;
    gr_we           = 1'b0;
    dest            = 5'd0;
    data_sram_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset_in_ready",   32'(in_ready), 32'd0);
    checkOutput("reset_retire_cnt", retire_cnt,    32'd0);
    checkOutput("reset_rf_we",      32'(rf_we),    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Directed cases
    applyStimulus(8'b0000_0001, 32'h1000_0003, 32'h80FF_1234, 32'h0, 1'b1, 5'd5, 1'b1, 0);
    applyStimulus(8'b0001_0000, 32'h1000_0002, 32'hBEEF_0001, 32'h0, 1'b1, 5'd6, 1'b1, 0);
    applyStimulus(8'b0000_0010, 32'h1000_0002, 32'hBEEF_0001, 32'h0, 1'b1, 5'd6, 1'b1, 0);
    applyStimulus(8'b0000_0100, 32'h1000_0000, 32'h1234_5678, 32'hDEAD_DEAD, 1'b1, 5'd9, 1'b1, 3);
    applyStimulus(8'b0000_0000, 32'h0000_0005, 32'h0, 32'h0, 1'b1, 5'd0, 1'b0, 0);
    applyStimulus(8'b1000_0000, 32'h1000_0010, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1);
    idle(1);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      op = 8'(1 << $urandom_range(0, 7));
      else if (r < 85) op = 8'h00;
      else             op = 8'($urandom);
      applyStimulus(op, $urandom, $urandom, $urandom, 1'($urandom),
                    5'($urandom), 1'($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(1);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset while a load is stalled
    applyStimulus_partial();

    // Four back-to-back instructions after reset
    for (int n = 0; n < 4; n++) begin
      applyStimulus(8'b0000_0100, $urandom, $urandom, $urandom, 1'b1,
                    5'(n + 1), 1'b1, 0);
    end
    idle(1);
    @(negedge clk);
    checkOutput("retire_after_four", retire_cnt, 32'd4);
    checkOutput("queue_drained_end", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Stalled load interrupted by reset; the pending expectation is dropped
  // because that instruction never retires.
  task automatic applyStimulus_partial();
    exp_t e;
    e.we    = 1'b1;
    e.waddr = 5'd7;
    e.wdata = 32'hCAFE_F00D;
    e.fwd_v = 1'b1;
    exp_q.push_back(e);
    in_valid        = 1'b1;
    load_op         = 8'b0000_0100;
    alu_result      = 32'h2000_0000;
    gr_we           = 1'b1;
    dest            = 5'd7;
    res_from_mem    = 1'b1;
    data_sram_rdata = 32'hCAFE_F00D;
    commit_ready    = 1'b0;
    @(posedge clk); #1;
    data_sram_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    rst          = 1'b1;
    commit_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_stall_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_stall_rf_we",    32'(rf_we),    32'd0);
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    exp_retire = 0;
    @(negedge clk);
    checkOutput("post_rst_retire_cnt", retire_cnt,      32'd0);
    checkOutput("post_rst_rf_we",      32'(rf_we),      32'd0);
    checkOutput("post_rst_in_ready",   32'(in_ready),   32'd1);
    checkOutput("post_rst_rdata_hold", dut.rdata_hold,  32'd0);
    @(posedge clk); #1;
  endtask

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final (write-back) stage of the in-order LA32R pipeline.
- Directly downstream of the memory stage: consumes its registered outputs and the data SRAM read data, which returns one cycle after the memory stage presents the address.
- Aligns and extends load data, holds that data while the stage is stalled, and commits register-file writes.
- Drives the bypass path to decode and a retired-instruction counter.

Parameters:
RESET_PC, 32'h1c000000, value of pc_q after reset
CNT_W, 32, width of retire counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  memory-stage out_valid
in_ready  out  1  to memory-stage out_ready
commit_ready  in  1  downstream commit permission (trace/back-pressure); tie 1 if unused
pc  in  32  instruction PC
alu_result  in  32  ALU result / load address
load_op  in  8  one-hot: [0]LD.B [1]LD.H [2]LD.W [3]LD.BU [4]LD.HU [5]ST.B [6]ST.H [7]ST.W
res_from_mem  in  1  result is load data
gr_we  in  1  writes GPR
dest  in  5  destination GPR
data_sram_rdata  in  32  SRAM read data, valid in first cycle after transfer
rf_we  out  1  register-file write enable
rf_waddr  out  5  write address
rf_wdata  out  32  write data
fwd_valid  out  1  bypass valid to decode
fwd_dest  out  5  bypass register
fwd_data  out  32  bypass value
retire_cnt  out  CNT_W  committed instruction count

Behaviour:
- Handshake:
  - in_ready = ~rst & (~in_valid | commit_ready).
  - commit = in_valid & commit_ready; an instruction retires in exactly one commit cycle.
  - Inputs other than data_sram_rdata are stable while in_valid & ~in_ready.
- Freshness tracking:
  - accept_q <= in_ready every cycle; reset 0.
  - Cycle is "fresh" when in_valid & accept_q; data_sram_rdata belongs to the current instruction only then.
- Hold buffer:
  - On a fresh cycle, rdata_hold <= data_sram_rdata.
  - rdata_eff = accept_q ? data_sram_rdata : rdata_hold.
  - A stall of any length must yield the original read data at commit.
  - rdata_hold resets to 0.
- Load alignment (combinational from rdata_eff, alu_result[1:0]):
  - byte = rdata_eff[8*a +: 8].
  - half = rdata_eff[16*a[1] +: 16]; a[0] is ignored.
  - LD.B/LD.H sign-extend; LD.BU/LD.HU zero-extend; LD.W passes the full word and ignores a.
  - No load bit set, or more than one: load value is the OR of masked candidates (0 when none set).
- Result: wdata = res_from_mem ? load value : alu_result.
- Commit outputs:
  - rf_we = commit & gr_we; rf_waddr = dest; rf_wdata = wdata.
  - Writes to r0 are passed through; the register file ignores them.
- Bypass:
  - fwd_valid = in_valid & gr_we & (dest != 0); fwd_dest = dest; fwd_data = wdata.
  - Valid during stalls, including load results.
- Retire counter: retire_cnt increments by 1 on each commit, wraps at 2^CNT_W, resets to 0.
- pc_q: latches pc on commit, reset RESET_PC; used only for trace.
- Reset mid-stall: the hold buffer and accept_q clear; in_ready is 0 during rst; no rf_we in the reset cycle.
- Latency: zero added cycles; the instruction commits in the first cycle in which it is valid and commit_ready=1.

Optional Feature:
- WB_TRACE_EN defined:
  - Adds outputs debug_wb_pc[31:0] = pc, debug_wb_rf_we[3:0] = {4{rf_we}}, debug_wb_rf_wnum = dest, debug_wb_rf_wdata = wdata.
  - These outputs are qualified by commit.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - load_op bit-index constants (LOP_LDB..LOP_STW) and width 8.
  - RESET_PC default.
  - Register address width 5.
- Natural sub-module: load_align (rdata, addr[1:0], load_op → 32-bit value), purely combinational, reused by any future cache refill path.

Test Plan:
- LD.B, addr low bits 2'b11, rdata 32'h80FF_1234, commit_ready=1 → rf_we=1, rf_wdata=32'hFFFF_FF80 in the same cycle.
- LD.HU, addr 2'b10, rdata 32'hBEEF_0001 → rf_wdata=32'h0000_BEEF; LD.H same inputs → 32'hFFFF_BEEF.
- LD.W, commit_ready=0 for 3 cycles, data_sram_rdata changes to 32'hDEAD_DEAD after the first cycle (originally 32'h1234_5678):
  - in_ready=0 and fwd_valid=1 with fwd_data=32'h1234_5678 throughout.
  - On commit, rf_wdata=32'h1234_5678 and retire_cnt increments by exactly 1.
- Non-load ADD, gr_we=1, dest=0, alu_result=5 → rf_we=1 with waddr 0, fwd_valid=0.
- Store (load_op[7], gr_we=0) → rf_we=0, retire_cnt increments; back-to-back 4 instructions → retire_cnt=4.
- rst asserted during a stalled load → next cycle in_ready=0 → after release, retire_cnt=0, rdata_hold=0, no spurious rf_we.
